// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared types and constants for the OCI debug-RAM arbiter.
package cpu_debug_ocimem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Single-bit grant encoding: the round-robin arbiter inverts last_grant on conflict.
    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_JTAG = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        JTAG_RD = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_debug_ocimem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant advances only on an enabled grant.
module rr_arbiter2
    import cpu_debug_ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic req_cpu_i,
    input  logic req_jtag_i,
    output logic gnt_vld_o,
    output logic gnt_o
);

    logic last_q;

    always_comb begin
        gnt_vld_o = en_i & (req_cpu_i | req_jtag_i);
        if (req_cpu_i & req_jtag_i)
            gnt_o = ~last_q;
        else if (req_jtag_i)
            gnt_o = GNT_JTAG;
        else
            gnt_o = GNT_CPU;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= GNT_JTAG;
        else if (gnt_vld_o)
            last_q <= gnt_o;
    end

endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug slave and the CPU Avalon slave.
module cpu_debug_ocimem_arbiter
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr_in,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic              jpend_q, jpend_d;
    logic              jwr_q;
    logic [DATA_W-1:0] jwdata_q;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [DATA_W-1:0] jrdata_q;
    logic              jdone_q;
    logic              jovr_q;

    logic gnt_vld, gnt;
    logic gnt_cpu, gnt_jtag;
    logic cpu_wr_go, cpu_rd_go, jtag_wr_go, jtag_rd_go;
    logic jtag_cmpl, intake_ok;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .en_i       ((state_q == IDLE) & ~reset),
        .req_cpu_i  (avs_read | avs_write),
        .req_jtag_i (jpend_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_o      (gnt)
    );

    assign gnt_cpu    = gnt_vld & (gnt == GNT_CPU);
    assign gnt_jtag   = gnt_vld & (gnt == GNT_JTAG);
    assign cpu_wr_go  = gnt_cpu & avs_write;
    assign cpu_rd_go  = gnt_cpu & ~avs_write;
    assign jtag_wr_go = gnt_jtag & jwr_q;
    assign jtag_rd_go = gnt_jtag & ~jwr_q;
    assign jtag_cmpl  = jtag_wr_go | (state_q == JTAG_RD);
    // A request is refused while one is queued or its read data is still returning.
    assign intake_ok  = jtag_req & ~jpend_q & (state_q != JTAG_RD);

    assign avs_waitrequest = reset | ~(cpu_wr_go | (state_q == CPU_RD));
    assign avs_readdata    = ram_rdata;
    assign ram_we          = cpu_wr_go | jtag_wr_go;
    assign ram_addr        = gnt_jtag ? jaddr_q  : avs_address;
    assign ram_wdata       = gnt_jtag ? jwdata_q : avs_writedata;

    assign jtag_rdata   = jrdata_q;
    assign jtag_done    = jdone_q;
    assign jtag_overrun = jovr_q;
    assign jtag_addr    = jaddr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_rd_go)
                    state_d = CPU_RD;
                else if (jtag_rd_go)
                    state_d = JTAG_RD;
            end
            CPU_RD:  state_d = IDLE;
            JTAG_RD: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        jaddr_d = jaddr_q;
        if (jtag_cmpl)
            jaddr_d = jaddr_q + ADDR_W'(1);
        if (jtag_addr_load)
            jaddr_d = jtag_addr_in;

        jpend_d = jpend_q;
        if (jtag_cmpl)
            jpend_d = 1'b0;
        if (intake_ok)
            jpend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            jpend_q  <= 1'b0;
            jwr_q    <= 1'b0;
            jwdata_q <= '0;
            jaddr_q  <= '0;
            jrdata_q <= '0;
            jdone_q  <= 1'b0;
            jovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            jpend_q <= jpend_d;
            jaddr_q <= jaddr_d;
            jdone_q <= jtag_cmpl;
            if (intake_ok) begin
                jwr_q    <= jtag_wr;
                jwdata_q <= jtag_wdata;
            end
            if (state_q == JTAG_RD)
                jrdata_q <= ram_rdata;
            if (jtag_req & ~intake_ok)
                jovr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Directed bench: transaction-level model checked every cycle plus literal expectations.
module tb_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        avs_read, avs_write;
    logic [7:0]  avs_address;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        jtag_addr_load;
    logic [7:0]  jtag_addr_in;
    logic        jtag_req, jtag_wr;
    logic [31:0] jtag_wdata;
    logic [31:0] jtag_rdata;
    logic        jtag_done, jtag_overrun;
    logic [7:0]  jtag_addr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    int tests = 0;
    int fails = 0;

    cpu_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata),
        .jtag_addr_load(jtag_addr_load), .jtag_addr_in(jtag_addr_in),
        .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_overrun(jtag_overrun),
        .jtag_addr(jtag_addr),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM this cycle and what each side must see.
    int          m_phase;   // 0 free, 1 CPU read data returning, 2 JTAG read data returning
    bit          m_pend, m_pwr, m_last_cpu, m_done, m_ovr;
    logic [31:0] m_pwdata, m_rdata, m_rd_val, m_jrd_val;
    logic [7:0]  m_ptr;
    logic [31:0] m_mem [256];

    always @(negedge clk) begin : model
        bit cpu_wants, go_cpu, go_jtag, finish, old_pend;
        int old_phase;
        if (reset) begin
            m_phase = 0; m_pend = 0; m_last_cpu = 0; m_done = 0; m_ovr = 0;
            m_rdata = '0; m_ptr = '0;
            chk("m_rst_wait", avs_waitrequest, 1);
            chk("m_rst_we", ram_we, 0);
            chk("m_rst_done", jtag_done, 0);
            chk("m_rst_ovr", jtag_overrun, 0);
            chk("m_rst_ptr", jtag_addr, 0);
            chk("m_rst_rdata", jtag_rdata, 0);
        end else begin
            chk("m_done", jtag_done, m_done);
            chk("m_jrdata", jtag_rdata, m_rdata);
            chk("m_ovr", jtag_overrun, m_ovr);
            chk("m_ptr", jtag_addr, m_ptr);
            cpu_wants = avs_read | avs_write;
            old_pend  = m_pend;
            old_phase = m_phase;
            finish    = 0;
            if (m_phase == 1) begin
                chk("m_cpurd_wait", avs_waitrequest, 0);
                chk("m_cpurd_data", avs_readdata, m_rd_val);
                chk("m_cpurd_we", ram_we, 0);
                m_phase = 0;
            end else if (m_phase == 2) begin
                if (cpu_wants) chk("m_jrd_cpuwait", avs_waitrequest, 1);
                chk("m_jrd_we", ram_we, 0);
                m_rdata = m_jrd_val;
                finish  = 1;
                m_phase = 0;
            end else begin
                go_cpu  = 0;
                go_jtag = 0;
                if (cpu_wants && m_pend) begin
                    if (m_last_cpu) go_jtag = 1; else go_cpu = 1;
                end else if (cpu_wants) go_cpu = 1;
                else if (m_pend) go_jtag = 1;
                if (go_cpu) begin
                    m_last_cpu = 1;
                    if (avs_write) begin
                        chk("m_cpuwr_wait", avs_waitrequest, 0);
                        chk("m_cpuwr_we", ram_we, 1);
                        chk("m_cpuwr_addr", ram_addr, avs_address);
                        chk("m_cpuwr_data", ram_wdata, avs_writedata);
                        m_mem[avs_address] = avs_writedata;
                    end else begin
                        chk("m_cpurq_wait", avs_waitrequest, 1);
                        chk("m_cpurq_we", ram_we, 0);
                        m_rd_val = m_mem[avs_address];
                        m_phase  = 1;
                    end
                end
                if (go_jtag) begin
                    m_last_cpu = 0;
                    if (cpu_wants) chk("m_jg_cpuwait", avs_waitrequest, 1);
                    if (m_pwr) begin
                        chk("m_jwr_we", ram_we, 1);
                        chk("m_jwr_addr", ram_addr, m_ptr);
                        chk("m_jwr_data", ram_wdata, m_pwdata);
                        m_mem[m_ptr] = m_pwdata;
                        finish = 1;
                    end else begin
                        chk("m_jrq_we", ram_we, 0);
                        m_jrd_val = m_mem[m_ptr];
                        m_phase   = 2;
                    end
                end
                if (!go_cpu && !go_jtag) chk("m_idle_we", ram_we, 0);
            end
            if (finish) m_pend = 0;
            if (jtag_req) begin
                if (old_pend || old_phase == 2) m_ovr = 1;
                else begin
                    m_pend = 1; m_pwr = jtag_wr; m_pwdata = jtag_wdata;
                end
            end
            m_done = finish;
            if (jtag_addr_load) m_ptr = jtag_addr_in;
            else if (finish) m_ptr = m_ptr + 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            samp();
            if (jtag_done) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int cnt;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'hA5A5_0000 | i;
            m_mem[i] = 32'hA5A5_0000 | i;
        end
        reset = 1; avs_read = 0; avs_write = 1; avs_address = 8'h03; avs_writedata = 32'h1;
        jtag_addr_load = 0; jtag_addr_in = 0; jtag_req = 0; jtag_wr = 0; jtag_wdata = 0;
        repeat (2) step();
        samp();
        chk("L_rst_wait", avs_waitrequest, 1);
        chk("L_rst_we", ram_we, 0);
        chk("L_rst_ptr", jtag_addr, 8'h00);

        // CPU write 0xDEADBEEF @0x05, then read it back
        step();
        reset = 0; avs_write = 1; avs_address = 8'h05; avs_writedata = 32'hDEADBEEF;
        samp();
        chk("L_cwr_wait", avs_waitrequest, 0);
        chk("L_cwr_we", ram_we, 1);
        chk("L_cwr_addr", ram_addr, 8'h05);
        step();
        avs_write = 0; avs_read = 1;
        samp();
        chk("L_crd1_wait", avs_waitrequest, 1);
        step();
        samp();
        chk("L_crd2_wait", avs_waitrequest, 0);
        chk("L_crd2_data", avs_readdata, 32'hDEADBEEF);
        step();
        avs_read = 0;

        // Pointer load 0xFF with JTAG write same cycle, wrap, then JTAG read of 0x00
        jtag_addr_load = 1; jtag_addr_in = 8'hFF; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h1234;
        step();
        jtag_addr_load = 0; jtag_req = 0;
        samp();
        chk("L_jwr_we", ram_we, 1);
        chk("L_jwr_addr", ram_addr, 8'hFF);
        chk("L_jwr_data", ram_wdata, 32'h1234);
        step();
        samp();
        chk("L_jwr_done", jtag_done, 1);
        chk("L_wrap_ptr", jtag_addr, 8'h00);
        step();
        jtag_req = 1; jtag_wr = 0;
        step();
        jtag_req = 0;
        wait_done(10, ok);
        chk("L_jrd_seen", ok, 1);
        chk("L_jrd_data", jtag_rdata, 32'hA5A5_0000);
        chk("L_jrd_ptr", jtag_addr, 8'h01);
        step();

        // CPU read + jtag_req together, CPU re-requests: CPU, then JTAG, then CPU
        avs_read = 1; avs_address = 8'h05; jtag_req = 1; jtag_wr = 0;
        samp();
        chk("L_rr1_wait", avs_waitrequest, 1);
        step();
        jtag_req = 0;
        samp();
        chk("L_rr1_data", avs_readdata, 32'hDEADBEEF);
        step();
        avs_address = 8'h06;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("L_rr_jtag_wait", avs_waitrequest, 1);
            step();
        end
        samp();
        chk("L_rr2_wait", avs_waitrequest, 0);
        chk("L_rr2_data", avs_readdata, 32'hA5A5_0006);
        chk("L_rr2_ptr", jtag_addr, 8'h02);
        step();
        avs_read = 0;

        // Second jtag_req during JTAG_RD is dropped
        samp();
        chk("L_ovr_clear", jtag_overrun, 0);
        step();
        jtag_req = 1; jtag_wr = 0;
        step();
        jtag_req = 0;
        step();
        jtag_req = 1;
        step();
        jtag_req = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            samp();
            if (jtag_done) cnt++;
            step();
        end
        chk("L_one_done", cnt, 1);
        chk("L_ovr_set", jtag_overrun, 1);

        // Reset during CPU_RD with a JTAG write pending
        avs_read = 1; avs_address = 8'h05; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h55;
        step();
        jtag_req = 0;
        reset = 1;
        samp();
        chk("L_mrst_wait", avs_waitrequest, 1);
        chk("L_mrst_ptr", jtag_addr, 8'h00);
        chk("L_mrst_ovr", jtag_overrun, 0);
        step();
        step();
        reset = 0; avs_read = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            samp();
            if (jtag_done) cnt++;
            step();
        end
        chk("L_mrst_nodone", cnt, 0);

        // First conflict after reset goes to the CPU
        jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'hCAFE0001;
        step();
        jtag_req = 0; avs_write = 1; avs_address = 8'h09; avs_writedata = 32'h99;
        samp();
        chk("L_c1_wait", avs_waitrequest, 0);
        chk("L_c1_addr", ram_addr, 8'h09);
        step();
        avs_write = 0;
        samp();
        chk("L_c2_we", ram_we, 1);
        chk("L_c2_addr", ram_addr, 8'h00);
        chk("L_c2_data", ram_wdata, 32'hCAFE0001);
        step();
        samp();
        chk("L_c2_done", jtag_done, 1);
        chk("L_c2_ptr", jtag_addr, 8'h01);

        // Load 0x10 coinciding with write completion at 0x20: load wins
        step();
        jtag_addr_load = 1; jtag_addr_in = 8'h20; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h77;
        step();
        jtag_addr_in = 8'h10; jtag_req = 0;
        samp();
        chk("L_lw_addr", ram_addr, 8'h20);
        chk("L_lw_we", ram_we, 1);
        step();
        jtag_addr_load = 0;
        samp();
        chk("L_lw_ptr", jtag_addr, 8'h10);
        chk("L_lw_done", jtag_done, 1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
